uplink_capture_ctrl: RTL and testbench
======================================

// Module: uplink_capture_ctrl
// PURPOSE
// Sequences capture of lpGBT uplink frames (clk40 domain) into the dataframe store buffer.
// Software arms a capture, then the block waits for a trigger: immediate, header pattern or external.
// It then writes N consecutive valid frames to a dual-port buffer, counts FEC errors and reports status.
// The AXI side reads the buffer and status. The synchroniser for those status bits lives outside this block.
// PARAMETERS
// DATA_W   234  uplink user-data width (bits per frame)
// ADDR_W   10   buffer address width; depth = 2**ADDR_W frames
// CNT_W    32   FEC error counter width
// PORTS
// clk40_i           in   1         40 MHz uplink clock; the only clock
// rst40_i           in   1         synchronous, active-high reset
// uplinkUserData_i  in   DATA_W    uplink frame data
// uplinkrdy_i       in   1         frame valid / link ready
// uplinkFEC_i       in   1         FEC corrected error flag for current frame
// cfg_arm_i         in   1         single-cycle pulse: start new capture
// cfg_abort_i       in   1         single-cycle pulse: abort capture
// cfg_len_i         in   ADDR_W+1  frames to capture; 0 means 2**ADDR_W
// cfg_trig_mode_i   in   2         0 immediate, 1 pattern, 2 external, 3 reserved (= immediate)
// cfg_trig_mask_i   in   32        mask applied to uplinkUserData_i[31:0]
// cfg_trig_value_i  in   32        value compared under mask
// ext_trig_i        in   1         external trigger, level sampled in ARMED
// buf_we_o          out  1         buffer write enable
// buf_addr_o        out  ADDR_W    buffer write address
// buf_data_o        out  DATA_W    buffer write data
// sts_state_o       out  2         0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE
// sts_done_o        out  1         capture completed (sticky until next arm)
// sts_link_lost_o   out  1         capture ended early on uplinkrdy_i loss (sticky)
// sts_nframes_o     out  ADDR_W+1  frames written in current/last capture
// sts_fec_err_o     out  CNT_W     FEC errors in captured frames, saturating
// BEHAVIOUR
// - Reset: state IDLE; every output 0; buf_data_o 0.
// - Accepted frame: uplinkrdy_i=1 in CAPTURE, or the trigger cycle in ARMED.
//   - Frames with uplinkrdy_i=0 are never written and never counted.
// - Write latency 1: a frame accepted at cycle n gives buf_we_o=1 at n+1, with addr = sts_nframes_o(old) and data = that frame.
// - Config latch: all cfg_*/mode/mask/value/len are latched on an accepted arm; later changes are ignored until re-arm.
// - Length rules: len 0 -> 2**ADDR_W; len > 2**ADDR_W is clamped to 2**ADDR_W.
// - IDLE/DONE + cfg_arm_i -> ARMED next cycle.
//   - Clears done, link_lost, nframes and fec_err.
// - cfg_arm_i in ARMED/CAPTURE is ignored.
// - ARMED: trigger condition by mode:
//   - immediate: uplinkrdy_i=1
//   - pattern: uplinkrdy_i=1 and (data[31:0] & mask) == (value & mask)
//   - external: ext_trig_i=1 and uplinkrdy_i=1
//   - When the condition holds, the trigger frame is the first captured frame and state -> CAPTURE.
//   - uplinkrdy_i=0 in ARMED only delays the trigger; it is not an error.
// - CAPTURE: each accepted frame increments nframes.
//   - Add 1 to fec_err when uplinkFEC_i=1, saturating at all-ones.
//   - When nframes reaches len -> DONE and sts_done_o=1, in the same cycle as the last buf_we_o.
//   - len=1 goes ARMED -> CAPTURE -> DONE with exactly one write.
// - CAPTURE + uplinkrdy_i=0 -> DONE with sts_link_lost_o=1 and sts_done_o=1.
//   - Frames already written remain valid; nframes reports them.
// - cfg_abort_i in any state -> IDLE next cycle.
//   - No write is issued for a frame accepted in that cycle.
//   - done is not set; nframes and fec_err are retained.
//   - Abort and arm in the same cycle: abort wins.
// - A pending write (from cycle n) still completes at n+1 even if abort or link loss occurs at n+1.
// - Reset mid-capture: immediate IDLE; buffer contents undefined to software.
// - Addresses never wrap within one capture, because nframes <= 2**ADDR_W.
// STRUCTURE
// - Package uplink_capture_pkg holds:
//   - state enum (IDLE/ARMED/CAPTURE/DONE)
//   - trig_mode enum
//   - localparams for DATA_W defaults and header field width 32
// - Sub-module capture_trig_match: combinational masked compare plus mode mux; outputs a trig_hit bit.
// - The FSM, counters and write-port register stay in the top level.
// TESTING
// - Immediate, len=4, rdy=1 throughout, frames D0..D3 -> 4 writes at addr 0..3, data D0..D3, done=1, nframes=4.
// - Pattern mask=0xFF value=0xA5, 0xA5 arrives on frame 7 -> first write carries frame 7 at addr 0; frames 0..6 not written.
// - len=8, rdy drops after 3 captured frames -> link_lost=1, done=1, nframes=3, state DONE.
// - FEC=1 on 2 of 5 captured frames and on frames outside capture -> fec_err=2; CNT_W=4 bench, 20 errors -> saturates at 15.
// - Abort in the same cycle as arm during CAPTURE with len=16 -> IDLE next cycle, no further writes, done=0, nframes kept.
// - len=0, ADDR_W=4 -> exactly 16 writes at addr 0..15, then DONE; a re-arm clears status and captures again from addr 0.

Source files
------------

// File: rtl/uplink_capture_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uplink_capture_pkg
//  Description : Shared types and constants for the uplink frame capture
//                controller: capture state encoding, trigger mode encoding,
//                default frame width and trigger header field width.
//  Revision    : 1.0 - initial release
// ============================================================================
package uplink_capture_pkg;

  // Default lpGBT uplink user-data width in bits.
  localparam int DATA_W_DEF = 234;

  // The trigger compare looks only at the low header field of a frame.
  localparam int HDR_W = 32;

  typedef enum logic [1:0] {
    CAP_IDLE    = 2'd0,
    CAP_ARMED   = 2'd1,
    CAP_CAPTURE = 2'd2,
    CAP_DONE    = 2'd3
  } cap_state_e;

  typedef enum logic [1:0] {
    TRIG_IMMEDIATE = 2'd0,
    TRIG_PATTERN   = 2'd1,
    TRIG_EXTERNAL  = 2'd2,
    TRIG_RESERVED  = 2'd3
  } trig_mode_e;

endpackage
`default_nettype wire

// File: rtl/capture_trig_match.sv
`default_nettype none
// ============================================================================
//  Module      : capture_trig_match
//  Description : Combinational trigger qualifier. Compares the frame header
//                field against value under mask and selects the trigger
//                condition for the configured mode. A hit always requires
//                the frame to be valid.
//  Ports       : trig_mode - trigger mode (reserved behaves as immediate)
//                hdr       - low header field of the current frame
//                mask      - compare mask
//                value     - compare value
//                rdy       - current frame valid
//                ext_trig  - external trigger level
//                trig_hit  - trigger condition holds this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module capture_trig_match
  import uplink_capture_pkg::*;
(
  input  logic [1:0]       trig_mode,
  input  logic [HDR_W-1:0] hdr,
  input  logic [HDR_W-1:0] mask,
  input  logic [HDR_W-1:0] value,
  input  logic             rdy,
  input  logic             ext_trig,
  output logic             trig_hit
);

  logic w_pat_eq;

  always_comb begin
    // Bits outside the mask never influence the match.
    w_pat_eq = ((hdr ^ value) & mask) == '0;
    trig_hit = 1'b0;
    case (trig_mode_e'(trig_mode))
      TRIG_PATTERN:  trig_hit = rdy & w_pat_eq;
      TRIG_EXTERNAL: trig_hit = rdy & ext_trig;
      default:       trig_hit = rdy;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/uplink_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : uplink_capture_ctrl
//  Description : Sequences capture of lpGBT uplink frames into the dataframe
//                store buffer. Software arms a capture; the block waits for a
//                trigger (immediate, header pattern or external), then writes
//                N consecutive valid frames to the buffer write port, counts
//                FEC-corrected frames and reports status.
//  Ports       : clk40_i / rst40_i     - uplink clock, sync active-high reset
//                uplink*_i             - frame data, valid, FEC flag
//                cfg_*_i               - arm/abort pulses and capture config
//                ext_trig_i            - external trigger level
//                buf_we/addr/data_o    - buffer write port (1-cycle latency)
//                sts_*_o               - state, done, link lost, frame count,
//                                        saturating FEC error count
//  Revision    : 1.0 - initial release
// ============================================================================
module uplink_capture_ctrl
  import uplink_capture_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 32
) (
  input  logic              clk40_i,
  input  logic              rst40_i,
  input  logic [DATA_W-1:0] uplinkUserData_i,
  input  logic              uplinkrdy_i,
  input  logic              uplinkFEC_i,
  input  logic              cfg_arm_i,
  input  logic              cfg_abort_i,
  input  logic [ADDR_W:0]   cfg_len_i,
  input  logic [1:0]        cfg_trig_mode_i,
  input  logic [31:0]       cfg_trig_mask_i,
  input  logic [31:0]       cfg_trig_value_i,
  input  logic              ext_trig_i,
  output logic              buf_we_o,
  output logic [ADDR_W-1:0] buf_addr_o,
  output logic [DATA_W-1:0] buf_data_o,
  output logic [1:0]        sts_state_o,
  output logic              sts_done_o,
  output logic              sts_link_lost_o,
  output logic [ADDR_W:0]   sts_nframes_o,
  output logic [CNT_W-1:0]  sts_fec_err_o
);

  localparam logic [1:0] C_ST_IDLE    = 2'(CAP_IDLE);
  localparam logic [1:0] C_ST_ARMED   = 2'(CAP_ARMED);
  localparam logic [1:0] C_ST_CAPTURE = 2'(CAP_CAPTURE);
  localparam logic [1:0] C_ST_DONE    = 2'(CAP_DONE);

  // Full buffer depth, also the largest legal capture length.
  localparam logic [ADDR_W:0] C_DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [1:0]        r_state;
  logic [1:0]        r_mode;
  logic [HDR_W-1:0]  r_mask;
  logic [HDR_W-1:0]  r_value;
  logic [ADDR_W:0]   r_len;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_done;
  logic              r_lost;
  logic [ADDR_W:0]   r_nframes;
  logic [CNT_W-1:0]  r_fec;

  logic              w_hit;
  logic              w_accept;
  logic [ADDR_W:0]   w_nf_next;
  logic              w_last;
  logic [ADDR_W:0]   w_len_eff;

  capture_trig_match u_trig_match (
    .trig_mode (r_mode),
    .hdr       (uplinkUserData_i[HDR_W-1:0]),
    .mask      (r_mask),
    .value     (r_value),
    .rdy       (uplinkrdy_i),
    .ext_trig  (ext_trig_i),
    .trig_hit  (w_hit)
  );

  always_comb begin
    // Zero and oversize lengths both mean "fill the whole buffer".
    w_len_eff = ((cfg_len_i == '0) || (cfg_len_i > C_DEPTH)) ? C_DEPTH : cfg_len_i;
    // The trigger frame itself is the first captured frame.
    w_accept  = ((r_state == C_ST_ARMED) && w_hit) ||
                ((r_state == C_ST_CAPTURE) && uplinkrdy_i);
    w_nf_next = r_nframes + 1'b1;
    w_last    = (w_nf_next == r_len);
  end

  always_ff @(posedge clk40_i) begin
    if (rst40_i) begin
      r_state   <= C_ST_IDLE;
      r_mode    <= '0;
      r_mask    <= '0;
      r_value   <= '0;
      r_len     <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_done    <= 1'b0;
      r_lost    <= 1'b0;
      r_nframes <= '0;
      r_fec     <= '0;
    end else begin
      r_we <= 1'b0;
      if (cfg_abort_i) begin
        // Abort drops any frame accepted this cycle and keeps the counters.
        r_state <= C_ST_IDLE;
      end else begin
        if (w_accept) begin
          r_we      <= 1'b1;
          r_addr    <= r_nframes[ADDR_W-1:0];
          r_data    <= uplinkUserData_i;
          r_nframes <= w_nf_next;
          if (uplinkFEC_i && (r_fec != {CNT_W{1'b1}})) begin
            r_fec <= r_fec + 1'b1;
          end
        end

        case (r_state)
          C_ST_IDLE, C_ST_DONE: begin
            if (cfg_arm_i) begin
              r_state   <= C_ST_ARMED;
              r_mode    <= cfg_trig_mode_i;
              r_mask    <= cfg_trig_mask_i;
              r_value   <= cfg_trig_value_i;
              r_len     <= w_len_eff;
              r_done    <= 1'b0;
              r_lost    <= 1'b0;
              r_nframes <= '0;
              r_fec     <= '0;
            end
          end
          C_ST_ARMED: begin
            // Without a hit the block simply keeps waiting.
            if (w_hit) begin
              r_state <= w_last ? C_ST_DONE : C_ST_CAPTURE;
              r_done  <= w_last;
            end
          end
          C_ST_CAPTURE: begin
            if (!uplinkrdy_i) begin
              r_state <= C_ST_DONE;
              r_done  <= 1'b1;
              r_lost  <= 1'b1;
            end else if (w_last) begin
              r_state <= C_ST_DONE;
              r_done  <= 1'b1;
            end
          end
          default: r_state <= C_ST_IDLE;
        endcase
      end
    end
  end

  assign buf_we_o        = r_we;
  assign buf_addr_o      = r_addr;
  assign buf_data_o      = r_data;
  assign sts_state_o     = r_state;
  assign sts_done_o      = r_done;
  assign sts_link_lost_o = r_lost;
  assign sts_nframes_o   = r_nframes;
  assign sts_fec_err_o   = r_fec;

endmodule
`default_nettype wire

// File: tb/tb_uplink_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uplink_capture_ctrl
//  Description : Self-checking bench for uplink_capture_ctrl with a small
//                buffer (16 frames), narrow FEC counter (4 bits) and 64-bit
//                frames. Expected writes and status come from a frame-list
//                reference model of the capture rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uplink_capture_ctrl;

  localparam int DW = 64;
  localparam int AW = 4;
  localparam int CW = 4;
  localparam int NMAX = 64;

  logic          clk40_i = 1'b0;
  logic          rst40_i = 1'b1;
  logic [DW-1:0] uplinkUserData_i = '0;
  logic          uplinkrdy_i = 1'b0;
  logic          uplinkFEC_i = 1'b0;
  logic          cfg_arm_i = 1'b0;
  logic          cfg_abort_i = 1'b0;
  logic [AW:0]   cfg_len_i = '0;
  logic [1:0]    cfg_trig_mode_i = '0;
  logic [31:0]   cfg_trig_mask_i = '0;
  logic [31:0]   cfg_trig_value_i = '0;
  logic          ext_trig_i = 1'b0;
  logic          buf_we_o;
  logic [AW-1:0] buf_addr_o;
  logic [DW-1:0] buf_data_o;
  logic [1:0]    sts_state_o;
  logic          sts_done_o;
  logic          sts_link_lost_o;
  logic [AW:0]   sts_nframes_o;
  logic [CW-1:0] sts_fec_err_o;

  uplink_capture_ctrl #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk40_i          (clk40_i),
    .rst40_i          (rst40_i),
    .uplinkUserData_i (uplinkUserData_i),
    .uplinkrdy_i      (uplinkrdy_i),
    .uplinkFEC_i      (uplinkFEC_i),
    .cfg_arm_i        (cfg_arm_i),
    .cfg_abort_i      (cfg_abort_i),
    .cfg_len_i        (cfg_len_i),
    .cfg_trig_mode_i  (cfg_trig_mode_i),
    .cfg_trig_mask_i  (cfg_trig_mask_i),
    .cfg_trig_value_i (cfg_trig_value_i),
    .ext_trig_i       (ext_trig_i),
    .buf_we_o         (buf_we_o),
    .buf_addr_o       (buf_addr_o),
    .buf_data_o       (buf_data_o),
    .sts_state_o      (sts_state_o),
    .sts_done_o       (sts_done_o),
    .sts_link_lost_o  (sts_link_lost_o),
    .sts_nframes_o    (sts_nframes_o),
    .sts_fec_err_o    (sts_fec_err_o)
  );

  always #5 clk40_i = ~clk40_i;

  int checks = 0;
  int errors = 0;

  // Frame stimulus list shared by the scenario tasks.
  logic [DW-1:0] f_data [NMAX];
  bit            f_rdy  [NMAX];
  bit            f_fec  [NMAX];
  bit            f_ext  [NMAX];

  // Observed buffer writes.
  logic [AW-1:0] obs_addr [$];
  logic [DW-1:0] obs_data [$];
  bit            obs_done [$];

  // Expected buffer writes.
  logic [AW-1:0] exp_addr [$];
  logic [DW-1:0] exp_data [$];
  bit            exp_done [$];

  always @(negedge clk40_i) begin
    if (buf_we_o === 1'b1) begin
      obs_addr.push_back(buf_addr_o);
      obs_data.push_back(buf_data_o);
      obs_done.push_back(sts_done_o);
    end
  end

  task automatic tick();
    @(posedge clk40_i);
    #1;
  endtask

  task automatic clear_writes();
    obs_addr.delete(); obs_data.delete(); obs_done.delete();
    exp_addr.delete(); exp_data.delete(); exp_done.delete();
  endtask

  task automatic compare_writes(input string name);
    checks++;
    if (obs_addr.size() !== exp_addr.size()) begin
      errors++;
      $display("FAIL %s write count: got %0d expected %0d", name, obs_addr.size(), exp_addr.size());
    end
    for (int k = 0; k < obs_addr.size() && k < exp_addr.size(); k++) begin
      checks++;
      if (obs_addr[k] !== exp_addr[k] || obs_data[k] !== exp_data[k] || obs_done[k] !== exp_done[k]) begin
        errors++;
        $display("FAIL %s write %0d: got addr %0d data %h done %0d expected addr %0d data %h done %0d",
                 name, k, obs_addr[k], obs_data[k], obs_done[k], exp_addr[k], exp_data[k], exp_done[k]);
      end
    end
  endtask

  task automatic check_status(input string name, input logic [1:0] st, input bit dn, input bit lost,
                              input int nfr, input int fec);
    checks++;
    if (sts_state_o !== st || sts_done_o !== dn || sts_link_lost_o !== lost ||
        sts_nframes_o !== (AW+1)'(nfr) || sts_fec_err_o !== CW'(fec)) begin
      errors++;
      $display("FAIL %s status: got state %0d done %0d lost %0d nframes %0d fec %0d expected state %0d done %0d lost %0d nframes %0d fec %0d",
               name, sts_state_o, sts_done_o, sts_link_lost_o, sts_nframes_o, sts_fec_err_o,
               st, dn, lost, nfr, fec);
    end
  endtask

  function automatic logic [DW-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // Arms one capture, plays frames 0..n-1 (one per cycle), idles the link,
  // then checks writes and status against the frame-list model.
  task automatic run_capture(input string name, input logic [1:0] mode, input logic [31:0] mask,
                             input logic [31:0] value, input logic [AW:0] len, input int n);
    int leff, trig, cnt, fec;
    bit lost, hit;
    clear_writes();
    cfg_trig_mode_i = mode; cfg_trig_mask_i = mask; cfg_trig_value_i = value; cfg_len_i = len;
    uplinkrdy_i = 1'b0; uplinkFEC_i = 1'b0; ext_trig_i = 1'b0;
    cfg_arm_i = 1'b1;
    tick();
    cfg_arm_i = 1'b0;
    check_status({name, " after arm"}, 2'd1, 1'b0, 1'b0, 0, 0);
    // Configuration must have been latched at arm time.
    cfg_trig_mode_i = 2'($urandom()); cfg_trig_mask_i = $urandom(); cfg_trig_value_i = $urandom();
    cfg_len_i = (AW+1)'($urandom());
    for (int i = 0; i < n; i++) begin
      uplinkUserData_i = f_data[i]; uplinkrdy_i = f_rdy[i]; uplinkFEC_i = f_fec[i]; ext_trig_i = f_ext[i];
      tick();
    end
    uplinkrdy_i = 1'b0; uplinkFEC_i = 1'b0; ext_trig_i = 1'b0;
    repeat (3) tick();

    leff = (len == 0 || int'(len) > (1 << AW)) ? (1 << AW) : int'(len);
    trig = -1;
    for (int i = 0; i < n; i++) begin
      if (!f_rdy[i]) continue;
      case (mode)
        2'd1:    hit = ((f_data[i][31:0] & mask) == (value & mask));
        2'd2:    hit = f_ext[i];
        default: hit = 1'b1;
      endcase
      if (hit) begin trig = i; break; end
    end
    cnt = 0; fec = 0; lost = 1'b0;
    if (trig >= 0) begin
      for (int i = trig; cnt < leff; i++) begin
        if (i >= n || !f_rdy[i]) begin lost = 1'b1; break; end
        exp_addr.push_back(AW'(cnt));
        exp_data.push_back(f_data[i]);
        fec += int'(f_fec[i]);
        cnt++;
      end
    end
    for (int k = 0; k < cnt; k++) exp_done.push_back(k == cnt - 1 && !lost);
    compare_writes(name);
    check_status({name, " final"}, (trig < 0) ? 2'd1 : 2'd3, trig >= 0, lost, cnt,
                 (fec > (1 << CW) - 1) ? (1 << CW) - 1 : fec);
    if (trig < 0) begin
      cfg_abort_i = 1'b1; tick(); cfg_abort_i = 1'b0;
    end
  endtask

  task automatic fill_frames(input int n, input bit rdy, input bit fec);
    for (int i = 0; i < NMAX; i++) begin
      f_data[i] = rnd64(); f_rdy[i] = (i < n) ? rdy : 1'b0; f_fec[i] = fec; f_ext[i] = 1'b0;
    end
  endtask

  task automatic test_reset();
    cfg_arm_i = 1'b1; uplinkrdy_i = 1'b1; uplinkUserData_i = rnd64();
    rst40_i = 1'b1;
    repeat (3) tick();
    cfg_arm_i = 1'b0; uplinkrdy_i = 1'b0;
    rst40_i = 1'b0;
    checks++;
    if (buf_we_o !== 1'b0 || buf_addr_o !== '0 || buf_data_o !== '0) begin
      errors++;
      $display("FAIL reset write port: got we %0d addr %0d data %h expected all 0", buf_we_o, buf_addr_o, buf_data_o);
    end
    check_status("reset", 2'd0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_immediate();
    fill_frames(6, 1'b1, 1'b0);
    run_capture("immediate len4", 2'd0, 32'h0, 32'h0, 5'd4, 6);
  endtask

  task automatic test_pattern();
    fill_frames(12, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      if (f_data[i][7:0] == 8'hA5) f_data[i][0] = ~f_data[i][0];
      f_fec[i] = 1'b1;
    end
    f_data[3][7:0] = 8'hA5; f_rdy[3] = 1'b0;
    f_data[7][7:0] = 8'hA5;
    f_fec[8] = 1'b1;
    run_capture("pattern A5", 2'd1, 32'hFF, 32'h5A5A_00A5, 5'd4, 12);
  endtask

  task automatic test_external();
    fill_frames(8, 1'b1, 1'b0);
    f_ext[2] = 1'b1; f_rdy[2] = 1'b0;
    f_ext[4] = 1'b1;
    run_capture("external", 2'd2, 32'h0, 32'h0, 5'd3, 8);
  endtask

  task automatic test_link_loss();
    fill_frames(8, 1'b1, 1'b0);
    f_rdy[0] = 1'b0; f_rdy[4] = 1'b0;
    run_capture("link loss", 2'd0, 32'h0, 32'h0, 5'd8, 8);
  endtask

  task automatic test_fec();
    fill_frames(10, 1'b1, 1'b0);
    f_rdy[0] = 1'b0; f_fec[0] = 1'b1; f_rdy[1] = 1'b0; f_fec[1] = 1'b1;
    f_fec[2] = 1'b1; f_fec[5] = 1'b1;
    f_fec[7] = 1'b1; f_fec[8] = 1'b1; f_fec[9] = 1'b1;
    run_capture("fec count", 2'd0, 32'h0, 32'h0, 5'd5, 10);
    fill_frames(20, 1'b1, 1'b1);
    run_capture("fec saturate len0", 2'd0, 32'h0, 32'h0, 5'd0, 20);
  endtask

  task automatic test_len_clamp();
    fill_frames(20, 1'b1, 1'b0);
    run_capture("len clamp 20", 2'd3, 32'h0, 32'h0, 5'd20, 20);
    fill_frames(4, 1'b1, 1'b0);
    run_capture("len 1", 2'd0, 32'h0, 32'h0, 5'd1, 4);
  endtask

  task automatic test_abort();
    int fec;
    clear_writes();
    cfg_trig_mode_i = 2'd0; cfg_len_i = 5'd16;
    cfg_arm_i = 1'b1; tick(); cfg_arm_i = 1'b0;
    fec = 0;
    for (int i = 0; i < 10; i++) begin
      uplinkUserData_i = rnd64(); uplinkrdy_i = 1'b1; uplinkFEC_i = 1'($urandom());
      // Arm at frame 2 must be ignored; arm+abort at frame 5 aborts.
      cfg_arm_i = (i == 2 || i == 5); cfg_abort_i = (i == 5);
      if (i < 5) begin
        exp_addr.push_back(AW'(i)); exp_data.push_back(uplinkUserData_i); exp_done.push_back(1'b0);
        fec += int'(uplinkFEC_i);
      end
      tick();
      if (i == 5) check_status("abort next cycle", 2'd0, 1'b0, 1'b0, 5, fec);
    end
    cfg_arm_i = 1'b0; cfg_abort_i = 1'b0; uplinkrdy_i = 1'b0; uplinkFEC_i = 1'b0;
    repeat (2) tick();
    compare_writes("abort");
    check_status("abort final", 2'd0, 1'b0, 1'b0, 5, fec);
  endtask

  task automatic test_reset_mid();
    cfg_trig_mode_i = 2'd0; cfg_len_i = 5'd8;
    cfg_arm_i = 1'b1; tick(); cfg_arm_i = 1'b0;
    uplinkrdy_i = 1'b1;
    repeat (3) begin uplinkUserData_i = rnd64(); tick(); end
    rst40_i = 1'b1; tick(); rst40_i = 1'b0; uplinkrdy_i = 1'b0;
    checks++;
    if (buf_we_o !== 1'b0) begin
      errors++;
      $display("FAIL reset mid write enable: got %0d expected 0", buf_we_o);
    end
    check_status("reset mid", 2'd0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_random();
    logic [1:0] mode;
    for (int it = 0; it < 12; it++) begin
      mode = 2'($urandom());
      for (int i = 0; i < NMAX; i++) begin
        f_data[i] = rnd64();
        f_rdy[i]  = (i < 30) && ($urandom_range(0, 9) != 0);
        f_fec[i]  = 1'($urandom());
        f_ext[i]  = ($urandom_range(0, 3) == 0);
      end
      run_capture($sformatf("random %0d", it), mode, 32'h0000_000F, $urandom(),
                  (AW+1)'($urandom_range(0, 31)), 30);
    end
  endtask

  initial begin
    test_reset();
    test_immediate();
    test_pattern();
    test_external();
    test_link_loss();
    test_fec();
    test_len_clamp();
    test_abort();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
